axi4_lite_master_ctrl: RTL and testbench

AXI4_LITE_MASTER_CTRL -- requirements
Module: axi4_lite_master_ctrl

---
 rtl/axi4_lite_pkg.sv | 18 +
 rtl/axi4_lite_master_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_master_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - AXI4-Lite response codes and master FSM state encoding
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_master_ctrl.sv
// rtl/axi4_lite_master_ctrl.sv - AXI4-Lite single-outstanding master controller
//
// Turns one command (read or write) into AXI4-Lite channel traffic and returns
// one response. Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_write, cmd_addr, cmd_prot,
//                                cmd_wdata, cmd_wstrb)
//   rsp_valid/rsp_ready          response handshake (rsp_write, rsp_rdata,
//                                rsp_resp, rsp_timeout)
//   aw*, w*, b*, ar*, r*         AXI4-Lite master channels
//   busy                         high whenever the FSM is not idle
module axi4_lite_master_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [2:0]          cmd_prot,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy
);

  state_t state;

  // Gated with areset so the handshake is withheld while reset is held,
  // even though the state register already sits in IDLE.
  assign cmd_ready = (state == ST_IDLE) && !areset;
  assign busy      = (state != ST_IDLE);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             cmd_write_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      awaddr    <= '0;
      awprot    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arprot    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      wd_cnt      <= '0;
      cmd_write_q <= 1'b0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
`ifdef AXIL_MASTER_TIMEOUT_EN
            wd_cnt      <= '0;
            cmd_write_q <= cmd_write;
            rsp_timeout <= 1'b0;
`endif
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              awprot  <= cmd_prot;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= ST_WR_REQ;
            end else begin
              araddr  <= cmd_addr;
              arprot  <= cmd_prot;
              arvalid <= 1'b1;
              state   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently; a channel whose valid is already
          // low has finished its handshake on an earlier cycle.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= bresp;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Placed after the case so an expiry overrides any same-cycle progress.
      if (state inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA}) begin
        if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          awvalid     <= 1'b0;
          wvalid      <= 1'b0;
          bready      <= 1'b0;
          arvalid     <= 1'b0;
          rready      <= 1'b0;
          rsp_write   <= cmd_write_q;
          rsp_rdata   <= '0;
          rsp_resp    <= RESP_SLVERR;
          rsp_timeout <= 1'b1;
          rsp_valid   <= 1'b1;
          state       <= ST_RESP;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// tb/tb_axi4_lite_master_ctrl.sv - self-checking bench for axi4_lite_master_ctrl
module tb_axi4_lite_master_ctrl;

  localparam int TO_CYC = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_prot = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  axi4_lite_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [159:0] all_out();
    return {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
            awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
            araddr, arprot, arvalid, rready, busy};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  // One command plus a bench-side slave with per-channel ready/valid delays.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] bresp_v, input int ar_dly, input int r_dly,
                         input logic [1:0] rresp_v, input int rsp_dly,
                         input bit exp_to, input bit exp_got, input int limit);
    logic [31:0] exp_rdata, s_addr, s_data;
    logic [1:0]  exp_resp;
    logic [3:0]  s_strb;
    bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0, wrote = 0;
    bit aw_f, w_f, b_f, ar_f, r_f;
    int b_wait = 0, r_wait = 0, b_cnt = 0, cyc = 0, n = 0;
    s_addr = '0; s_data = '0; s_strb = '0;

    exp_resp  = exp_to ? 2'b10 : (wr ? bresp_v : rresp_v);
    exp_rdata = ref_rd(addr);
    if (wr && !exp_to && exp_got) ref_mem[addr] = merge(exp_rdata, data, strb);

    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_prot = prot;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    chk("busy_after_accept", busy, 1);
    if (wr) begin
      chk("aw_w_valid_latency", {awvalid, wvalid, arvalid}, 3'b110);
      chk("aw_payload", {awaddr, awprot}, {addr, prot});
      chk("w_payload", {wdata, wstrb}, {data, strb});
    end else begin
      chk("ar_valid_latency", {awvalid, wvalid, arvalid}, 3'b001);
      chk("ar_payload", {araddr, arprot}, {addr, prot});
    end

    while (!rsp_valid && cyc < limit) begin
      awready = wr && !aw_done && cyc >= aw_dly;
      wready  = wr && !w_done && cyc >= w_dly;
      bvalid  = aw_done && w_done && !b_done && b_wait >= b_dly;
      bresp   = bresp_v;
      arready = !wr && !ar_done && cyc >= ar_dly;
      rvalid  = ar_done && !r_done && r_wait >= r_dly;
      rresp   = rresp_v;
      rdata   = slv_rd(s_addr);
      aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bvalid && bready;
      ar_f = arvalid && arready; r_f = rvalid && rready;
      if (aw_f) s_addr = awaddr;
      if (ar_f) s_addr = araddr;
      if (w_f) begin s_data = wdata; s_strb = wstrb; end
      tick();
      cyc++;
      if (aw_done && w_done) b_wait++;
      if (ar_done) r_wait++;
      if (aw_f) begin aw_done = 1; chk("aw_drop_after_hs", awvalid, 0); end
      if (w_f)  begin w_done = 1;  chk("w_drop_after_hs", wvalid, 0); end
      if (ar_f) begin ar_done = 1; chk("ar_drop_after_hs", arvalid, 0); end
      if (b_f)  begin b_done = 1; b_cnt++; end
      if (r_f)  r_done = 1;
      if (wr && !exp_to && !aw_done) chk("aw_hold_until_hs", {awvalid, awaddr}, {1'b1, addr});
      if (wr && !exp_to && !w_done)  chk("w_hold_until_hs", {wvalid, wdata}, {1'b1, data});
      if (aw_done && w_done && !wrote) begin
        slv_mem[s_addr] = merge(slv_rd(s_addr), s_data, s_strb);
        wrote = 1;
      end
    end
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;

    chk("rsp_arrival", rsp_valid, exp_got);
    if (exp_to) begin
      chk("timeout_busy_cycles", cyc, TO_CYC);
      chk("timeout_axi_idle", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    end
    if (!exp_got) return;
    if (wr && !exp_to) chk("single_b_handshake", b_cnt, 1);

    for (int k = 0; k <= rsp_dly; k++) begin
      rsp_ready = (k == rsp_dly);
      chk("rsp_valid_held", {rsp_valid, busy, cmd_ready}, 3'b110);
      chk("rsp_write", rsp_write, wr);
      chk("rsp_resp", rsp_resp, exp_resp);
      chk("rsp_timeout", rsp_timeout, exp_to);
      if (!wr) chk("rsp_rdata", rsp_rdata, exp_rdata);
      tick();
    end
    rsp_ready = 0;
    chk("idle_after_rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    int n_acc, acc2, rsp1;
    bit wr;
    logic [31:0] a;

    tick();
    chk("reset_outputs_zero", all_out(), '0);
    tick();
    areset = 1'b0;
    tick();
    chk("post_reset_idle", {cmd_ready, busy, rsp_valid}, 3'b100);

    // Write 0xDEADBEEF to 0x10, AW/W ready together, OKAY.
    run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 100);
    // W accepted three cycles before AW.
    run_txn(1, 32'h14, 32'hA5A55A5A, 4'hF, 3'b010, 3, 0, 1, 2'b00, 0, 0, 2'b00, 1, 0, 1, 100);
    // AW before W.
    run_txn(1, 32'h18, 32'h01020304, 4'h5, 3'b001, 0, 2, 0, 2'b11, 0, 0, 2'b00, 0, 0, 1, 100);
    // Address 0 / data 0 are legal, then load 0x12345678 at address 0.
    run_txn(1, 32'h0, 32'h0, 4'hF, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 100);
    run_txn(1, 32'h0, 32'h12345678, 4'hF, 3'b000, 1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 100);
    // Read 0x0 with SLVERR, response held through 4 cycles of rsp_ready low.
    run_txn(0, 32'h0, 32'h0, 4'h0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b10, 4, 0, 1, 100);
    run_txn(0, 32'h10, 32'h0, 4'h0, 3'b100, 0, 0, 0, 2'b00, 2, 3, 2'b00, 0, 0, 1, 100);

    // Randomized mixed traffic over a small address window.
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7)) << 2;
      run_txn(wr, a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 3), 0, 1, 100);
    end

    // Reset pulsed while waiting in RD_DATA.
    cmd_write = 0; cmd_addr = 32'h20; cmd_prot = 3'b101; cmd_valid = 1;
    chk("rst_case_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0; arready = 1;
    tick();
    arready = 0;
    chk("rst_case_in_rd_data", {rready, busy}, 2'b11);
    #2 areset = 1'b1;
    #1 chk("async_reset_outputs_zero", all_out(), '0);
    #1 areset = 1'b0;
    rvalid = 1; rdata = 32'hCAFEF00D;
    tick();
    rvalid = 0;
    chk("after_reset_no_rsp", {rsp_valid, busy, cmd_ready, rready}, 4'b0010);
    tick();
    chk("after_reset_still_idle", {rsp_valid, busy}, 2'b00);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // AW never accepted: watchdog closes the transaction.
    run_txn(1, 32'h40, 32'h55AA55AA, 4'hF, 3'b000, 100000, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1, 1, 100);
`else
    // AW never accepted: without the watchdog the master keeps waiting.
    run_txn(1, 32'h40, 32'h55AA55AA, 4'hF, 3'b000, 100000, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 40);
    chk("no_watchdog_still_waiting", {busy, awvalid, rsp_timeout}, 3'b110);
    areset = 1'b1;
    #2 areset = 1'b0;
    tick();
    chk("recover_idle", {busy, cmd_ready}, 2'b01);
`endif

    // Back-to-back commands held on cmd_valid.
    cmd_write = 0; cmd_addr = 32'h8; cmd_prot = 3'b000; cmd_valid = 1;
    arready = 1; rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b00;
    n_acc = 0; acc2 = -1; rsp1 = -1;
    for (int c = 0; c < 20; c++) begin
      rsp_ready = (c >= 6);
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        if (n_acc == 2) acc2 = c;
      end
      if (rsp_valid && rsp_ready && rsp1 < 0) rsp1 = c;
      tick();
      if (n_acc == 2) cmd_valid = 0;
    end
    arready = 0; rvalid = 0; rsp_ready = 0;
    chk("b2b_accept_count", n_acc, 2);
    chk("b2b_second_after_rsp", (rsp1 >= 0) && (acc2 > rsp1), 1);
    chk("b2b_idle_at_end", {busy, rsp_valid, cmd_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
